// File: rtl/a51_keystream_core.sv
// a51_keystream_core: bit-serial A5/1 keystream engine.
// Loads a 64-bit key and a 22-bit frame number, runs 100 mixing steps,
// then emits 228 keystream bits as eight 32-bit words over valid/ready.
// Optional build macro A51_CONTINUOUS_EN: endless 32-bit word stream,
// ks_last_o tied low, start_i while busy restarts with a fresh key/frame.
module a51_keystream_core (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [63:0] key_i,
  input  logic [21:0] frame_i,
  output logic        busy_o,
  output logic [31:0] ks_word_o,
  output logic        ks_valid_o,
  input  logic        ks_ready_i,
  output logic        ks_last_o
);

`ifdef A51_CONTINUOUS_EN
  localparam logic CONT = 1'b1;
`else
  localparam logic CONT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_FRAME,
    S_MIX,
    S_GEN,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [63:0] r_key;
  logic [21:0] r_frame;
  logic [18:0] r_r1;
  logic [21:0] r_r2;
  logic [22:0] r_r3;
  logic [6:0]  r_cnt;
  logic [2:0]  r_widx;
  logic [31:0] r_word;
  logic        r_busy;
  logic        r_valid;
  logic        r_last;

  logic        w_maj;
  logic        w_inj;
  logic        w_step_all;
  logic        w_step_maj;
  logic        w_en1;
  logic        w_en2;
  logic        w_en3;
  logic [18:0] w_r1_nx;
  logic [21:0] w_r2_nx;
  logic [22:0] w_r3_nx;
  logic        w_ks_bit;
  logic [31:0] w_shift;
  logic        w_last_word;
  logic        w_gen_done;
  logic        w_restart;

  // Next-state of the three LFSRs and the keystream bit taken after the step
  always_comb begin
    w_maj      = (r_r1[8] & r_r2[10]) | (r_r1[8] & r_r3[10]) | (r_r2[10] & r_r3[10]);
    w_step_all = (r_state == S_KEY) || (r_state == S_FRAME);
    w_step_maj = (r_state == S_MIX) || (r_state == S_GEN);
    w_inj      = 1'b0;
    if (r_state == S_KEY) begin
      w_inj = r_key[0];
    end else if (r_state == S_FRAME) begin
      w_inj = r_frame[0];
    end
    w_en1 = w_step_all || (w_step_maj && (r_r1[8]  == w_maj));
    w_en2 = w_step_all || (w_step_maj && (r_r2[10] == w_maj));
    w_en3 = w_step_all || (w_step_maj && (r_r3[10] == w_maj));
    w_r1_nx = r_r1;
    w_r2_nx = r_r2;
    w_r3_nx = r_r3;
    if (w_en1) begin
      w_r1_nx = {r_r1[17:0], r_r1[13] ^ r_r1[16] ^ r_r1[17] ^ r_r1[18] ^ w_inj};
    end
    if (w_en2) begin
      w_r2_nx = {r_r2[20:0], r_r2[20] ^ r_r2[21] ^ w_inj};
    end
    if (w_en3) begin
      w_r3_nx = {r_r3[21:0], r_r3[7] ^ r_r3[20] ^ r_r3[21] ^ r_r3[22] ^ w_inj};
    end
    w_ks_bit    = w_r1_nx[18] ^ w_r2_nx[21] ^ w_r3_nx[22];
    w_shift     = {r_word[30:0], w_ks_bit};
    w_last_word = !CONT && (r_widx == 3'd7);
    w_gen_done  = (r_cnt == (w_last_word ? 7'd3 : 7'd31));
    w_restart   = start_i && ((r_state == S_IDLE) || (CONT && (r_state != S_IDLE)));
  end

  // Sequencer: load key, load frame, mix, then generate words with handshake
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_frame <= '0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_cnt   <= '0;
      r_widx  <= '0;
      r_word  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_restart) begin
      r_key   <= key_i;
      r_frame <= frame_i;
      r_r1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_cnt   <= '0;
      r_widx  <= '0;
      r_word  <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_state <= S_KEY;
    end else begin
      case (r_state)
        S_IDLE: begin
        end
        S_KEY: begin
          r_r1  <= w_r1_nx;
          r_r2  <= w_r2_nx;
          r_r3  <= w_r3_nx;
          r_key <= {1'b0, r_key[63:1]};
          if (r_cnt == 7'd63) begin
            r_cnt   <= '0;
            r_state <= S_FRAME;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_FRAME: begin
          r_r1    <= w_r1_nx;
          r_r2    <= w_r2_nx;
          r_r3    <= w_r3_nx;
          r_frame <= {1'b0, r_frame[21:1]};
          if (r_cnt == 7'd21) begin
            r_cnt   <= '0;
            r_state <= S_MIX;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_MIX: begin
          r_r1 <= w_r1_nx;
          r_r2 <= w_r2_nx;
          r_r3 <= w_r3_nx;
          if (r_cnt == 7'd99) begin
            r_cnt   <= '0;
            r_state <= S_GEN;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_GEN: begin
          r_r1 <= w_r1_nx;
          r_r2 <= w_r2_nx;
          r_r3 <= w_r3_nx;
          if (w_gen_done) begin
            // The short final word is left-justified so its first bit sits in [31]
            r_word  <= w_last_word ? {w_shift[3:0], 28'd0} : w_shift;
            r_valid <= 1'b1;
            r_last  <= w_last_word;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_word <= w_shift;
            r_cnt  <= r_cnt + 7'd1;
          end
        end
        S_WAIT: begin
          if (ks_ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_last_word) begin
              r_widx  <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_widx  <= r_widx + 3'd1;
              r_state <= S_GEN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign ks_word_o  = r_word;
  assign ks_valid_o = r_valid;
  assign ks_last_o  = r_last;

endmodule

// File: tb/tb_a51_keystream_core.sv
// Directed bench for a51_keystream_core: reset, all-zero key, published
// test vector, backpressure, ignored starts, reset during mixing and,
// when A51_CONTINUOUS_EN is defined, the continuous stream mode.
module tb_a51_keystream_core;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start_i;
  logic [63:0] key_i;
  logic [21:0] frame_i;
  logic        busy_o;
  logic [31:0] ks_word_o;
  logic        ks_valid_o;
  logic        ks_ready_i;
  logic        ks_last_o;

  localparam logic [63:0] VKEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] VFRAME = 22'h134;
  localparam logic [63:0] AKEY   = 64'h0123456789ABCDEF;

  int n_cmp;
  int n_bad;

  logic [31:0] got_w [8];
  logic        got_last [8];
  int          valid_cyc [8];
  int          got_n;
  bit          timed_out;
  bit          unstable;
  bit          last_bad;
  int          stalls;
  logic        end_busy;
  logic        end_valid;

  bit          model_bits [640];
  logic [31:0] exp_w [8];

  a51_keystream_core dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start_i   (start_i),
    .key_i     (key_i),
    .frame_i   (frame_i),
    .busy_o    (busy_o),
    .ks_word_o (ks_word_o),
    .ks_valid_o(ks_valid_o),
    .ks_ready_i(ks_ready_i),
    .ks_last_o (ks_last_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  // Reference algorithm: registers held right-aligned in 32-bit words
  function automatic bit [31:0] clk1(input bit [31:0] r, input bit [31:0] mask,
                                     input bit [31:0] taps);
    return ((r << 1) & mask) | {31'd0, ^(r & taps)};
  endfunction

  task automatic model_run(input logic [63:0] k, input logic [21:0] f, input int nbits);
    bit [31:0] a, b, c;
    bit m, x;
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 64; i++) begin
      a = clk1(a, 32'h07FFFF, 32'h072000);
      b = clk1(b, 32'h3FFFFF, 32'h300000);
      c = clk1(c, 32'h7FFFFF, 32'h700080);
      x = k[i];
      a[0] ^= x; b[0] ^= x; c[0] ^= x;
    end
    for (int i = 0; i < 22; i++) begin
      a = clk1(a, 32'h07FFFF, 32'h072000);
      b = clk1(b, 32'h3FFFFF, 32'h300000);
      c = clk1(c, 32'h7FFFFF, 32'h700080);
      x = f[i];
      a[0] ^= x; b[0] ^= x; c[0] ^= x;
    end
    for (int i = 0; i < 100 + nbits; i++) begin
      m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
      if (a[8]  == m) a = clk1(a, 32'h07FFFF, 32'h072000);
      if (b[10] == m) b = clk1(b, 32'h3FFFFF, 32'h300000);
      if (c[10] == m) c = clk1(c, 32'h7FFFFF, 32'h700080);
      if (i >= 100) model_bits[i-100] = a[18] ^ b[21] ^ c[22];
    end
  endtask

  task automatic build_burst_expect;
    logic [31:0] w;
    for (int k = 0; k < 8; k++) begin
      w = '0;
      for (int bt = 0; bt < 32; bt++)
        if (k < 7 || bt < 4) w[31-bt] = model_bits[32*k+bt];
      exp_w[k] = w;
    end
  endtask

  task automatic do_start(input logic [63:0] k, input logic [21:0] f);
    key_i   = k;
    frame_i = f;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
  endtask

  // Collects eight words; cycle numbers count edges after the start edge
  task automatic capture_burst(input bit rnd, input int inj_cyc,
                               input logic [63:0] inj_key, input bit inj_final);
    int cyc;
    bit holding;
    logic [31:0] held;
    got_n = 0; timed_out = 0; unstable = 0; last_bad = 0; stalls = 0;
    cyc = 0; holding = 0; held = '0;
    while (got_n < 8) begin
      tick;
      cyc++;
      start_i = 1'b0;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      if (holding && (ks_valid_o !== 1'b1 || ks_word_o !== held)) unstable = 1;
      holding = 0;
      if (ks_last_o === 1'b1 && ks_valid_o !== 1'b1) last_bad = 1;
      if (cyc == inj_cyc) begin
        start_i = 1'b1;
        key_i   = inj_key;
      end
      ks_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ks_valid_o === 1'b1) begin
        if (ks_ready_i) begin
          got_w[got_n]     = ks_word_o;
          got_last[got_n]  = ks_last_o;
          valid_cyc[got_n] = cyc;
          if (got_n == 7 && inj_final) begin
            start_i = 1'b1;
            key_i   = inj_key;
          end
          got_n++;
        end else begin
          holding = 1;
          held    = ks_word_o;
          stalls++;
        end
      end
    end
    tick;
    start_i   = 1'b0;
    end_busy  = busy_o;
    end_valid = ks_valid_o;
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1; start_i = 1'b0; ks_ready_i = 1'b0;
    key_i = '0; frame_i = '0;
    tick; tick;
    wb_rst_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_cmp++; if (ks_word_o !== 32'd0) begin n_bad++; $display("FAIL reset_word got %h exp 00000000", ks_word_o); end
    n_cmp++; if (ks_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", ks_valid_o); end
    n_cmp++; if (ks_last_o !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b exp 0", ks_last_o); end
  endtask

  task automatic test_zero_key;
    int exp_cyc;
    do_start(64'd0, 22'd0);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL zero_busy_start got %b exp 1", busy_o); end
    capture_burst(1'b0, -1, 64'd0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL zero_timeout got %0d words exp 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      exp_cyc = (k < 7) ? 218 + 33*k : 218 + 33*6 + 5;
      n_cmp++; if (got_w[k] !== 32'd0) begin n_bad++; $display("FAIL zero_word%0d got %h exp 00000000", k, got_w[k]); end
      n_cmp++; if (got_last[k] !== (k == 7)) begin n_bad++; $display("FAIL zero_last%0d got %b exp %b", k, got_last[k], k == 7); end
      n_cmp++; if (valid_cyc[k] !== exp_cyc) begin n_bad++; $display("FAIL zero_vcyc%0d got %0d exp %0d", k, valid_cyc[k], exp_cyc); end
    end
    n_cmp++; if (last_bad !== 1'b0) begin n_bad++; $display("FAIL zero_last_without_valid got %b exp 0", last_bad); end
    n_cmp++; if (end_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_end got %b exp 0", end_busy); end
    n_cmp++; if (end_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid_end got %b exp 0", end_valid); end
  endtask

  task automatic test_vector;
    model_run(VKEY, VFRAME, 228);
    build_burst_expect;
    n_cmp++; if (exp_w[0] !== 32'h534EAA58) begin n_bad++; $display("FAIL model_word1 got %h exp 534eaa58", exp_w[0]); end
    n_cmp++; if (exp_w[1] !== 32'h2FE8151A) begin n_bad++; $display("FAIL model_word2 got %h exp 2fe8151a", exp_w[1]); end
    do_start(VKEY, VFRAME);
    capture_burst(1'b0, 10, AKEY, 1'b1);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL vec_timeout got %0d words exp 8", got_n); end
    n_cmp++; if (got_w[0] !== 32'h534EAA58) begin n_bad++; $display("FAIL vec_word1 got %h exp 534eaa58", got_w[0]); end
    n_cmp++; if (got_w[1] !== 32'h2FE8151A) begin n_bad++; $display("FAIL vec_word2 got %h exp 2fe8151a", got_w[1]); end
    for (int k = 2; k < 8; k++) begin
      n_cmp++; if (got_w[k] !== exp_w[k]) begin n_bad++; $display("FAIL vec_word%0d got %h exp %h", k+1, got_w[k], exp_w[k]); end
    end
    n_cmp++; if (valid_cyc[0] !== 218) begin n_bad++; $display("FAIL vec_first_valid got %0d exp 218", valid_cyc[0]); end
    n_cmp++; if (end_busy !== 1'b0) begin n_bad++; $display("FAIL vec_start_at_final got busy %b exp 0", end_busy); end
    for (int i = 0; i < 5; i++) tick;
    n_cmp++; if (busy_o !== 1'b0 || ks_valid_o !== 1'b0) begin n_bad++; $display("FAIL vec_idle_hold got busy %b valid %b exp 0 0", busy_o, ks_valid_o); end
    do_start(AKEY, VFRAME);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL vec_restart_idle got busy %b exp 1", busy_o); end
    wb_rst_i = 1'b1;
    tick;
    wb_rst_i = 1'b0;
  endtask

  task automatic test_backpressure;
    model_run(VKEY, VFRAME, 228);
    build_burst_expect;
    do_start(VKEY, VFRAME);
    capture_burst(1'b1, -1, 64'd0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got %0d words exp 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got_w[k] !== exp_w[k]) begin n_bad++; $display("FAIL bp_word%0d got %h exp %h", k+1, got_w[k], exp_w[k]); end
    end
    n_cmp++; if (unstable !== 1'b0) begin n_bad++; $display("FAIL bp_word_stable got changed %b exp 0", unstable); end
    n_cmp++; if (valid_cyc[7] !== 421 + stalls) begin n_bad++; $display("FAIL bp_final_cycle got %0d exp %0d", valid_cyc[7], 421 + stalls); end
    n_cmp++; if (got_last[7] !== 1'b1) begin n_bad++; $display("FAIL bp_last got %b exp 1", got_last[7]); end
    n_cmp++; if (end_busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_end got %b exp 0", end_busy); end
    ks_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid_mix;
    model_run(VKEY, VFRAME, 228);
    build_burst_expect;
    do_start(VKEY, VFRAME);
    for (int i = 0; i < 119; i++) tick;
    wb_rst_i = 1'b1;
    tick;
    wb_rst_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL mix_rst_busy got %b exp 0", busy_o); end
    n_cmp++; if (ks_word_o !== 32'd0) begin n_bad++; $display("FAIL mix_rst_word got %h exp 00000000", ks_word_o); end
    n_cmp++; if (ks_valid_o !== 1'b0) begin n_bad++; $display("FAIL mix_rst_valid got %b exp 0", ks_valid_o); end
    n_cmp++; if (ks_last_o !== 1'b0) begin n_bad++; $display("FAIL mix_rst_last got %b exp 0", ks_last_o); end
    tick;
    do_start(VKEY, VFRAME);
    capture_burst(1'b0, -1, 64'd0, 1'b0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL mix_timeout got %0d words exp 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got_w[k] !== exp_w[k]) begin n_bad++; $display("FAIL mix_word%0d got %h exp %h", k+1, got_w[k], exp_w[k]); end
    end
    n_cmp++; if (valid_cyc[0] !== 218) begin n_bad++; $display("FAIL mix_first_valid got %0d exp 218", valid_cyc[0]); end
  endtask

  task automatic test_continuous;
    int cyc, n;
    logic [31:0] w [20];
    logic [31:0] e;
    bit lastseen;
    model_run(VKEY, VFRAME, 640);
    ks_ready_i = 1'b1;
    do_start(VKEY, VFRAME);
    n = 0; cyc = 0; lastseen = 0;
    while (n < 20 && cyc < 8000) begin
      tick;
      cyc++;
      if (ks_last_o !== 1'b0) lastseen = 1;
      if (ks_valid_o === 1'b1) begin
        w[n] = ks_word_o;
        n++;
        if (n == 20) start_i = 1'b1;
      end
    end
    n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL cont_timeout got %0d words exp 20", n); end
    for (int k = 0; k < n; k++) begin
      e = '0;
      for (int bt = 0; bt < 32; bt++) e[31-bt] = model_bits[32*k+bt];
      n_cmp++; if (w[k] !== e) begin n_bad++; $display("FAIL cont_word%0d got %h exp %h", k+1, w[k], e); end
    end
    tick;
    start_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL cont_busy_restart got %b exp 1", busy_o); end
    cyc = 0;
    while (ks_valid_o !== 1'b1 && cyc < 1000) begin
      tick;
      cyc++;
      if (ks_last_o !== 1'b0) lastseen = 1;
    end
    n_cmp++; if (cyc !== 218) begin n_bad++; $display("FAIL cont_restart_latency got %0d exp 218", cyc); end
    n_cmp++; if (ks_word_o !== 32'h534EAA58) begin n_bad++; $display("FAIL cont_restart_word got %h exp 534eaa58", ks_word_o); end
    n_cmp++; if (lastseen !== 1'b0) begin n_bad++; $display("FAIL cont_last_seen got %b exp 0", lastseen); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wb_rst_i = 1'b1; start_i = 1'b0; ks_ready_i = 1'b0;
    key_i = '0; frame_i = '0;
    test_reset;
`ifdef A51_CONTINUOUS_EN
    test_continuous;
`else
    test_zero_key;
    test_vector;
    test_backpressure;
    test_reset_mid_mix;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
